// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares a single sequential booth_mult8 between
// NUM_REQ requesters, with a start/done sequencer, watchdog and response channel.
module booth_mult_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [2*NUM_REQ-1:0]    req_sign,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_multiplicand,
    output logic [WIDTH-1:0]        mul_multiplier,
    output logic [1:0]              mul_sign_mode,
    input  logic [2*WIDTH-1:0]      mul_product,
    input  logic                    mul_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    rsp_timeout,
    output logic                    busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

    logic [1:0]       state;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  cur_id;
    logic [WD_W-1:0]  watchdog;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       sign_q;

    logic [WIDTH-1:0] a_arr    [NUM_REQ];
    logic [WIDTH-1:0] b_arr    [NUM_REQ];
    logic [1:0]       sign_arr [NUM_REQ];

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic             wrap_found;
    logic [ID_W-1:0]  wrap_idx;

    for (genvar j = 0; j < NUM_REQ; j++) begin : g_unpack
        assign a_arr[j]    = req_a[j*WIDTH +: WIDTH];
        assign b_arr[j]    = req_b[j*WIDTH +: WIDTH];
        assign sign_arr[j] = req_sign[2*j +: 2];
    end

    // Rotating priority: lowest valid index above last_grant wins, otherwise
    // wrap around to the lowest valid index at or below it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        wrap_found  = 1'b0;
        wrap_idx    = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j]) begin
                if (ID_W'(j) > last_grant) begin
                    if (!grant_found) begin
                        grant_found = 1'b1;
                        grant_idx   = ID_W'(j);
                    end
                end else if (!wrap_found) begin
                    wrap_found = 1'b1;
                    wrap_idx   = ID_W'(j);
                end
            end
        end
        if (!grant_found) begin
            grant_found = wrap_found;
            grant_idx   = wrap_idx;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= LAST_INIT;
            cur_id      <= '0;
            watchdog    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= '0;
            rsp_id      <= '0;
            rsp_product <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        a_q    <= a_arr[grant_idx];
                        b_q    <= b_arr[grant_idx];
                        sign_q <= sign_arr[grant_idx];
                        cur_id <= grant_idx;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    watchdog <= watchdog + 1'b1;
                    if (mul_done) begin
                        rsp_product <= mul_product;
                        rsp_timeout <= 1'b0;
                        rsp_id      <= cur_id;
                        state       <= RESP;
                    end else if (watchdog == WD_LAST) begin
                        rsp_product <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_id      <= cur_id;
                        state       <= RESP;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        last_grant <= cur_id;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

    assign mul_start        = (state == ISSUE);
    assign rsp_valid        = (state == RESP);
    assign busy             = (state != IDLE);
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign mul_sign_mode    = sign_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: behavioural 5-cycle multiplier stand-in plus
// arithmetic reference for products and rotating-priority grants.
module tb_booth_mult_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_sign;
    logic        mul_start;
    logic [7:0]  mul_multiplicand;
    logic [7:0]  mul_multiplier;
    logic [1:0]  mul_sign_mode;
    logic [15:0] mul_product;
    logic        mul_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_product;
    logic        rsp_timeout;
    logic        busy;

    int total = 0;
    int bad = 0;
    int model_last;
    int cyc = 0;
    int start_cnt = 0;
    int mcnt;
    logic mul_dead;

    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic [1:0] ts [4];

    always #5 clk = ~clk;

    booth_mult_arbiter #(
        .WIDTH(WIDTH),
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_sign(req_sign),
        .mul_start(mul_start),
        .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier),
        .mul_sign_mode(mul_sign_mode),
        .mul_product(mul_product),
        .mul_done(mul_done),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_product(rsp_product),
        .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b,
                                                input logic [1:0] s);
        longint ae;
        longint be;
        logic [63:0] p;
        ae = s[1] ? longint'($signed(a)) : longint'(a);
        be = s[0] ? longint'($signed(b)) : longint'(b);
        p = 64'(ae * be);
        return p[15:0];
    endfunction

    function automatic int ref_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Multiplier stand-in: done lands in the 5th cycle after the start edge;
    // it follows the arbiter's rst as the integrated rst_n = ~rst would.
    always @(posedge clk) begin
        if (rst) begin
            mcnt        <= 0;
            mul_done    <= 1'b0;
            mul_product <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_start) begin
                mcnt <= 1;
            end else if (mcnt != 0) begin
                if (mcnt == 4) begin
                    mcnt <= 0;
                    if (!mul_dead) begin
                        mul_done    <= 1'b1;
                        mul_product <= ref_product(mul_multiplicand, mul_multiplier, mul_sign_mode);
                    end
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_start) start_cnt <= start_cnt + 1;
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] s);
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
        req_sign[2*i +: 2] = s;
        ta[i] = a;
        tb[i] = b;
        ts[i] = s;
    endtask

    task automatic wait_grant(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_sign = '0;
        rsp_ready = 1'b0;
        mul_dead = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_last = 3;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++;
        if ({mul_start, mul_multiplicand, mul_multiplier, mul_sign_mode} !== 19'd0) begin
            bad++;
            $display("FAIL reset_mul_outs: got %b %h %h %b want all 0", mul_start,
                     mul_multiplicand, mul_multiplier, mul_sign_mode);
        end
        total++;
        if ({rsp_id, rsp_product, rsp_timeout, req_ready} !== 23'd0) begin
            bad++;
            $display("FAIL reset_rsp_outs: got id=%0d p=%h to=%b rdy=%b want all 0", rsp_id,
                     rsp_product, rsp_timeout, req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        int n;
        int s0;
        set_req(2, 8'hFD, 8'h07, 2'b11);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== (4'b0001 << ref_pick(4'b0100, model_last))) begin
            bad++; $display("FAIL single_grant: got %b want 0100", req_ready);
        end
        s0 = start_cnt;
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(n);
        total++;
        if (n != 7) begin bad++; $display("FAIL single_latency: got %0d want 7", n); end
        total++;
        if (rsp_id !== 2'd2) begin bad++; $display("FAIL single_id: got %0d want 2", rsp_id); end
        total++;
        if (rsp_product !== 16'hFFEB) begin
            bad++; $display("FAIL single_product: got %h want ffeb", rsp_product);
        end
        total++;
        if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL single_timeout: got %b want 0", rsp_timeout); end
        @(posedge clk);
        #1;
        total++;
        if (start_cnt - s0 != 1) begin
            bad++; $display("FAIL single_start_pulses: got %0d want 1", start_cnt - s0);
        end
        model_last = 2;
    endtask

    task automatic test_round_robin;
        int n;
        int exp;
        int prev;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_last = 3;
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'd10, 2'b00);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        prev = -1;
        for (int op = 0; op < 8; op++) begin
            exp = ref_pick(4'b1111, model_last);
            wait_grant(n);
            total++;
            if (n < 0 || req_ready !== (4'b0001 << exp)) begin
                bad++; $display("FAIL rr_grant op%0d: got %b want grant %0d", op, req_ready, exp);
            end
            if (prev >= 0) begin
                total++;
                if (cyc - prev != 8) begin
                    bad++; $display("FAIL rr_period op%0d: got %0d want 8", op, cyc - prev);
                end
            end
            prev = cyc;
            wait_rsp(n);
            total++;
            if (n < 0 || rsp_id !== 2'(exp) || rsp_product !== 16'((exp + 1) * 10)) begin
                bad++;
                $display("FAIL rr_rsp op%0d: got id=%0d p=%0d want id=%0d p=%0d", op, rsp_id,
                         rsp_product, exp, (exp + 1) * 10);
            end
            model_last = exp;
        end
        req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        int n;
        int exp;
        logic stable;
        logic [15:0] want;
        set_req(1, 8'($urandom), 8'($urandom), 2'($urandom));
        set_req(0, 8'($urandom), 8'($urandom), 2'($urandom));
        set_req(3, 8'($urandom), 8'($urandom), 2'($urandom));
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 4'b1001;
        wait_rsp(n);
        want = ref_product(ta[1], tb[1], ts[1]);
        total++;
        if (n < 0 || rsp_id !== 2'd1 || rsp_product !== want) begin
            bad++; $display("FAIL bp_rsp: got id=%0d p=%h want id=1 p=%h", rsp_id, rsp_product, want);
        end
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_product !== want ||
                rsp_timeout !== 1'b0 || req_ready !== 4'b0000) stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++; $display("FAIL bp_hold: got v=%b id=%0d p=%h rdy=%b want held response", rsp_valid,
                            rsp_id, rsp_product, req_ready);
        end
        rsp_ready = 1'b1;
        model_last = 1;
        exp = ref_pick(4'b1001, model_last);
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== (4'b0001 << exp)) begin
            bad++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 grant %0d", rsp_valid, req_ready, exp);
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(n);
        want = ref_product(ta[exp], tb[exp], ts[exp]);
        total++;
        if (n != 7 || rsp_id !== 2'(exp) || rsp_product !== want) begin
            bad++; $display("FAIL bp_next: got n=%0d id=%0d p=%h want n=7 id=%0d p=%h", n, rsp_id,
                            rsp_product, exp, want);
        end
        @(posedge clk);
        #1 model_last = exp;
    endtask

    task automatic test_mixed_sign;
        int n;
        logic [1:0]  modes  [2];
        logic [15:0] expect_p [2];
        modes[0] = 2'b00;
        modes[1] = 2'b10;
        expect_p[0] = 16'h01FE;
        expect_p[1] = 16'hFFFE;
        rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_req(0, 8'hFF, 8'h02, modes[k]);
            req_valid = 4'b0001;
            wait_grant(n);
            @(posedge clk);
            #1 req_valid = '0;
            wait_rsp(n);
            total++;
            if (n < 0 || rsp_product !== expect_p[k] || rsp_id !== 2'd0) begin
                bad++; $display("FAIL mixed_sign mode=%b: got id=%0d p=%h want id=0 p=%h", modes[k],
                                rsp_id, rsp_product, expect_p[k]);
            end
            @(posedge clk);
            #1;
        end
        model_last = 0;
    endtask

    task automatic test_watchdog;
        int n;
        logic [15:0] want;
        mul_dead = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 8'($urandom), 8'($urandom), 2'($urandom));
        req_valid = 4'b0010;
        wait_grant(n);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(n);
        total++;
        if (n != 18) begin bad++; $display("FAIL wd_latency: got %0d want 18", n); end
        total++;
        if (rsp_timeout !== 1'b1 || rsp_product !== 16'd0 || rsp_id !== 2'd1) begin
            bad++; $display("FAIL wd_rsp: got to=%b p=%h id=%0d want to=1 p=0 id=1", rsp_timeout,
                            rsp_product, rsp_id);
        end
        @(posedge clk);
        #1 mul_dead = 1'b0;
        model_last = 1;
        set_req(2, 8'($urandom), 8'($urandom), 2'($urandom));
        req_valid = 4'b0100;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || req_ready !== 4'b0100) begin
            bad++; $display("FAIL wd_recover_grant: got busy=%b rdy=%b want busy=0 rdy=0100", busy, req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(n);
        want = ref_product(ta[2], tb[2], ts[2]);
        total++;
        if (n != 7 || rsp_timeout !== 1'b0 || rsp_product !== want) begin
            bad++; $display("FAIL wd_recover_rsp: got n=%0d to=%b p=%h want n=7 to=0 p=%h", n,
                            rsp_timeout, rsp_product, want);
        end
        @(posedge clk);
        #1 model_last = 2;
    endtask

    task automatic test_reset_mid_wait;
        int n;
        logic [15:0] want;
        rsp_ready = 1'b1;
        set_req(1, 8'($urandom), 8'($urandom), 2'($urandom));
        req_valid = 4'b0010;
        wait_grant(n);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_last = 3;
        @(negedge clk);
        total++;
        if ({busy, rsp_valid, mul_start, rsp_timeout} !== 4'b0000 ||
            {mul_multiplicand, mul_multiplier, mul_sign_mode, rsp_product, rsp_id} !== 36'd0) begin
            bad++;
            $display("FAIL rst_mid_outs: got busy=%b v=%b st=%b a=%h b=%h p=%h want all 0", busy,
                     rsp_valid, mul_start, mul_multiplicand, mul_multiplier, rsp_product);
        end
        set_req(0, 8'($urandom), 8'($urandom), 2'($urandom));
        set_req(3, 8'($urandom), 8'($urandom), 2'($urandom));
        req_valid = 4'b1001;
        #1;
        total++;
        if (req_ready !== (4'b0001 << ref_pick(4'b1001, model_last))) begin
            bad++; $display("FAIL rst_mid_grant: got %b want 0001", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(n);
        want = ref_product(ta[0], tb[0], ts[0]);
        total++;
        if (n != 7 || rsp_id !== 2'd0 || rsp_product !== want) begin
            bad++; $display("FAIL rst_mid_rsp: got n=%0d id=%0d p=%h want n=7 id=0 p=%h", n, rsp_id,
                            rsp_product, want);
        end
        @(posedge clk);
        #1 model_last = 0;
    endtask

    task automatic test_random;
        int n;
        int exp;
        logic [3:0] mask;
        logic stable;
        logic acc;
        logic [15:0] want;
        for (int it = 0; it < 20; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) set_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
            req_valid = mask;
            exp = ref_pick(mask, model_last);
            @(negedge clk);
            total++;
            if (req_ready !== (4'b0001 << exp)) begin
                bad++; $display("FAIL rand_grant it%0d: got %b want grant %0d (mask %b)", it, req_ready, exp, mask);
            end
            @(posedge clk);
            #1 req_valid = '0;
            wait_rsp(n);
            want = ref_product(ta[exp], tb[exp], ts[exp]);
            total++;
            if (n != 7 || rsp_id !== 2'(exp) || rsp_product !== want || rsp_timeout !== 1'b0) begin
                bad++; $display("FAIL rand_rsp it%0d: got n=%0d id=%0d p=%h want n=7 id=%0d p=%h", it, n,
                                rsp_id, rsp_product, exp, want);
            end
            stable = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 20 && !acc; k++) begin
                rsp_ready = ($urandom_range(0, 2) == 0);
                if (rsp_ready) begin
                    @(posedge clk);
                    #1 acc = 1'b1;
                end else begin
                    @(negedge clk);
                    if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp) || rsp_product !== want) stable = 1'b0;
                end
            end
            if (!acc) begin
                rsp_ready = 1'b1;
                @(posedge clk);
                #1;
            end
            total++;
            if (!stable) begin
                bad++; $display("FAIL rand_hold it%0d: got v=%b id=%0d p=%h want held", it, rsp_valid,
                                rsp_id, rsp_product);
            end
            model_last = exp;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mixed_sign();
        test_watchdog();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
